// File: rtl/dm_arbiter.sv
// Two-port arbiter for the single-port data memory (CPU M-stage vs. DMA) with a word-by-word clear sequencer.
// Define DM_ARB_TRACE_EN to print every committed memory write.
module dm_arbiter #(
  parameter int DEPTH    = 3072,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [31:0] p0_pc,
  output logic        p0_gnt,
  output logic        p0_stall,
  output logic [31:0] p0_rdata,
  output logic        p0_rvalid,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic [31:0] p1_rdata,
  output logic        p1_rvalid,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic        clr_done,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_rd
);

  localparam int IW = $clog2(DEPTH);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [WW-1:0] wait_cnt_r;
  logic [IW-1:0] clr_idx_r;
  logic [31:0]   last_a_r;
  logic          clr_done_r;
  logic          p0_rvalid_r, p1_rvalid_r;
  logic [31:0]   p0_rdata_r, p1_rdata_r;

  logic          p0_gnt_s, p1_gnt_s, clr_last_s;
  logic [31:0]   mem_a_s, mem_wd_s, mem_pc_s;
  logic          mem_we_s;

  // Arbitration, memory drive and next-state; grants are held off while in reset.
  always_comb begin
    state_nxt_s = state_r;
    p0_gnt_s    = 1'b0;
    p1_gnt_s    = 1'b0;
    clr_last_s  = 1'b0;
    mem_a_s     = last_a_r;
    mem_wd_s    = 32'd0;
    mem_we_s    = 1'b0;
    mem_pc_s    = 32'd0;
    case (state_r)
      RUN: begin
        if (clr_start) begin
          state_nxt_s = CLEAR;
        end else if (rst_n && p0_req && !(p1_req && (wait_cnt_r >= WAIT_MAX))) begin
          p0_gnt_s = 1'b1;
          mem_a_s  = p0_addr;
          mem_wd_s = p0_wdata;
          mem_we_s = p0_we;
          mem_pc_s = p0_pc;
        end else if (rst_n && p1_req) begin
          p1_gnt_s = 1'b1;
          mem_a_s  = p1_addr;
          mem_wd_s = p1_wdata;
          mem_we_s = p1_we;
        end else begin
          mem_a_s = last_a_r;
        end
      end
      CLEAR: begin
        mem_we_s = 1'b1;
        mem_a_s  = 32'({clr_idx_r, 2'b00});
        if (clr_idx_r == LAST_IDX) begin
          clr_last_s  = 1'b1;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = CLEAR;
        end
      end
      default: begin
        state_nxt_s = RUN;
      end
    endcase
  end

  // FSM state, clear index, fairness counter and held memory address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= RUN;
      clr_idx_r  <= '0;
      wait_cnt_r <= '0;
      last_a_r   <= 32'd0;
      clr_done_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      last_a_r   <= mem_a_s;
      clr_done_r <= clr_last_s;
      if (state_r == CLEAR && !clr_last_s) begin
        clr_idx_r <= clr_idx_r + IW'(1);
      end else begin
        clr_idx_r <= '0;
      end
      if (p1_req && !p1_gnt_s) begin
        wait_cnt_r <= (wait_cnt_r >= WAIT_MAX) ? wait_cnt_r : wait_cnt_r + WW'(1);
      end else begin
        wait_cnt_r <= '0;
      end
    end
  end

  // Read-return registers: capture mem_rd on a read grant, pulse rvalid the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_rvalid_r <= 1'b0;
      p1_rvalid_r <= 1'b0;
      p0_rdata_r  <= 32'd0;
      p1_rdata_r  <= 32'd0;
    end else begin
      p0_rvalid_r <= p0_gnt_s && !p0_we;
      p1_rvalid_r <= p1_gnt_s && !p1_we;
      if (p0_gnt_s && !p0_we) begin
        p0_rdata_r <= mem_rd;
      end else begin
        p0_rdata_r <= p0_rdata_r;
      end
      if (p1_gnt_s && !p1_we) begin
        p1_rdata_r <= mem_rd;
      end else begin
        p1_rdata_r <= p1_rdata_r;
      end
    end
  end

`ifdef DM_ARB_TRACE_EN
  // Write trace; the CPU PC has already advanced one word past the store.
  always @(posedge clk) begin
    if (rst_n && mem_we_s) begin
      $display("%d@%h: *%h <= %h", $time, p0_gnt_s ? (p0_pc - 32'd4) : 32'd0, mem_a_s, mem_wd_s);
    end
  end
`endif

  assign p0_gnt    = p0_gnt_s;
  assign p1_gnt    = p1_gnt_s;
  assign p0_stall  = p0_req & ~p0_gnt_s;
  assign p0_rdata  = p0_rdata_r;
  assign p0_rvalid = p0_rvalid_r;
  assign p1_rdata  = p1_rdata_r;
  assign p1_rvalid = p1_rvalid_r;
  assign clr_busy  = (state_r == CLEAR);
  assign clr_done  = clr_done_r;
  assign mem_a     = mem_a_s;
  assign mem_wd    = mem_wd_s;
  assign mem_we    = mem_we_s;
  assign mem_pc    = mem_pc_s;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural single-port memory model.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we;
  logic [31:0] p0_addr, p0_wdata, p0_pc;
  logic        p0_gnt, p0_stall, p0_rvalid;
  logic [31:0] p0_rdata;
  logic        p1_req, p1_we;
  logic [31:0] p1_addr, p1_wdata;
  logic        p1_gnt, p1_rvalid;
  logic [31:0] p1_rdata;
  logic        clr_start, clr_busy, clr_done;
  logic [31:0] mem_a, mem_wd, mem_pc, mem_rd;
  logic        mem_we;

  logic [31:0] mem [0:4095];
  int tests = 0;
  int fails = 0;

  dm_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_pc(p0_pc),
    .p0_gnt(p0_gnt), .p0_stall(p0_stall), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_pc(mem_pc), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write at the rising edge.
  assign mem_rd = mem[mem_a[13:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_a[13:2]] <= mem_wd;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int n, gnt_seen, done_seen;
  logic [31:0] a_first, wd_first, a_last;
  logic        we_first;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    rst_n = 1'b0; clr_start = 1'b0;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = 32'd0; p0_wdata = 32'd0; p0_pc = 32'd0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'd0; p1_wdata = 32'd0;

    // Reset state
    #3;
    check("rst_p0_gnt", 32'(p0_gnt), 32'd0);
    check("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
    check("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
    check("rst_p0_rdata", p0_rdata, 32'd0);
    check("rst_p1_rdata", p1_rdata, 32'd0);
    check("rst_clr_busy", 32'(clr_busy), 32'd0);
    check("rst_clr_done", 32'(clr_done), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    #9 rst_n = 1'b1;

    // p0 write then read back
    step();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h10; p0_wdata = 32'hDEADBEEF; p0_pc = 32'h100;
    #1;
    check("wr_p0_gnt", 32'(p0_gnt), 32'd1);
    check("wr_mem_we", 32'(mem_we), 32'd1);
    check("wr_mem_a", mem_a, 32'h10);
    check("wr_mem_wd", mem_wd, 32'hDEADBEEF);
    check("wr_mem_pc", mem_pc, 32'h100);
    step();
    p0_we = 1'b0;
    #1;
    check("rd_p0_gnt", 32'(p0_gnt), 32'd1);
    check("wr_no_rvalid", 32'(p0_rvalid), 32'd0);
    step();
    p0_req = 1'b0;
    #1;
    check("rd_p0_rvalid", 32'(p0_rvalid), 32'd1);
    check("rd_p0_rdata", p0_rdata, 32'hDEADBEEF);
    check("idle_mem_we", 32'(mem_we), 32'd0);
    check("idle_mem_a_hold", mem_a, 32'h10);
    step();
    check("rvalid_pulse", 32'(p0_rvalid), 32'd0);
    check("rdata_hold", p0_rdata, 32'hDEADBEEF);

    // Contention: four p0 grants, then a forced p1 grant
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h14;
    #1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      check($sformatf("arb_p0_gnt_%0d", cyc), 32'(p0_gnt), (cyc % 5 != 4) ? 32'd1 : 32'd0);
      check($sformatf("arb_p1_gnt_%0d", cyc), 32'(p1_gnt), (cyc % 5 == 4) ? 32'd1 : 32'd0);
      check($sformatf("arb_stall_%0d", cyc), 32'(p0_stall), (cyc % 5 == 4) ? 32'd1 : 32'd0);
      check($sformatf("arb_p1_rvalid_%0d", cyc), 32'(p1_rvalid), (cyc == 5) ? 32'd1 : 32'd0);
      check($sformatf("arb_p0_rvalid_%0d", cyc), 32'(p0_rvalid), (cyc != 0 && cyc != 5) ? 32'd1 : 32'd0);
      step();
    end
    p0_req = 1'b0; p1_req = 1'b0;

    // p1 alone: write then read
    step();
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h20; p1_wdata = 32'h12345678;
    #1;
    check("p1wr_gnt", 32'(p1_gnt), 32'd1);
    check("p1wr_mem_we", 32'(mem_we), 32'd1);
    check("p1wr_mem_pc", mem_pc, 32'd0);
    step();
    p1_we = 1'b0;
    step();
    p1_req = 1'b0;
    #1;
    check("p1rd_rvalid", 32'(p1_rvalid), 32'd1);
    check("p1rd_rdata", p1_rdata, 32'h12345678);
    check("p1rd_p0_rvalid", 32'(p0_rvalid), 32'd0);

    // Fill both ends, then a full clear while p0 keeps requesting
    step();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h0; p0_wdata = 32'hAAAA5555;
    step();
    p0_addr = 32'h2FFC; p0_wdata = 32'h5555AAAA;
    step();
    p0_we = 1'b0; p0_addr = 32'h0; clr_start = 1'b1;
    #1;
    check("clrstart_p0_gnt", 32'(p0_gnt), 32'd0);
    check("clrstart_stall", 32'(p0_stall), 32'd1);
    check("clrstart_mem_we", 32'(mem_we), 32'd0);
    step();
    clr_start = 1'b0;
    n = 0; gnt_seen = 0; done_seen = 0;
    a_first = 32'hFFFFFFFF; wd_first = 32'hFFFFFFFF; we_first = 1'b0; a_last = 32'hFFFFFFFF;
    while (clr_busy && n < 4000) begin
      if (n == 0) begin a_first = mem_a; wd_first = mem_wd; we_first = mem_we; end
      if (n == 3071) a_last = mem_a;
      if (p0_gnt || p1_gnt) gnt_seen++;
      if (clr_done) done_seen++;
      n++;
      step();
    end
    check("clr_cycles", 32'(n), 32'd3072);
    check("clr_no_gnt", 32'(gnt_seen), 32'd0);
    check("clr_no_early_done", 32'(done_seen), 32'd0);
    check("clr_first_a", a_first, 32'h0);
    check("clr_first_wd", wd_first, 32'h0);
    check("clr_first_we", 32'(we_first), 32'd1);
    check("clr_last_a", a_last, 32'h2FFC);
    check("clr_done_pulse", 32'(clr_done), 32'd1);
    check("clr_busy_drop", 32'(clr_busy), 32'd0);
    check("post_clr_p0_gnt", 32'(p0_gnt), 32'd1);
    step();
    p0_req = 1'b0; p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h2FFC;
    #1;
    check("post_clr_rd0_valid", 32'(p0_rvalid), 32'd1);
    check("post_clr_rd0_data", p0_rdata, 32'd0);
    check("clr_done_single", 32'(clr_done), 32'd0);
    step();
    p1_req = 1'b0;
    check("post_clr_rdtop_valid", 32'(p1_rvalid), 32'd1);
    check("post_clr_rdtop_data", p1_rdata, 32'd0);

    // Asynchronous reset in the middle of a clear
    step();
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    n = 0;
    while (mem_a != 32'd400 && n < 200) begin
      step();
      n++;
    end
    check("midclr_reached_100", mem_a, 32'd400);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
    #1 rst_n = 1'b0;
    #1;
    check("async_clr_busy", 32'(clr_busy), 32'd0);
    check("async_mem_we", 32'(mem_we), 32'd0);
    check("async_p0_gnt", 32'(p0_gnt), 32'd0);
    check("async_mem_a", mem_a, 32'd0);
    check("async_clr_done", 32'(clr_done), 32'd0);
    step();
    check("inrst_clr_done", 32'(clr_done), 32'd0);
    #2 rst_n = 1'b1;
    #1;
    check("postrst_p0_gnt", 32'(p0_gnt), 32'd1);
    check("postrst_clr_busy", 32'(clr_busy), 32'd0);
    step();
    p0_req = 1'b0;
    check("postrst_rvalid", 32'(p0_rvalid), 32'd1);
    check("postrst_no_done", 32'(clr_done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the CPU M-stage, port 1 is an external/debug DMA master.
- Also owns a word-by-word memory-clear sequencer.
- Sits between the M-stage/DMA logic and the data memory. It drives the memory's address, write-data, write-enable and PC inputs, and samples its combinational read data.
- One memory access per cycle. Read data is registered and returned one cycle after grant.

Parameters:
- DEPTH, 3072, number of 32-bit words in the data memory; word index is addr[13:2].
- MAX_WAIT, 4, consecutive denied cycles of port 1 before it is force-granted over port 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- p0_req  input  1  CPU access request.
- p0_we  input  1  CPU write (1) / read (0).
- p0_addr  input  32  CPU byte address.
- p0_wdata  input  32  CPU write data.
- p0_pc  input  32  PC of the CPU instruction; forwarded to memory.
- p0_gnt  output  1  CPU request accepted this cycle (combinational).
- p0_stall  output  1  = p0_req & ~p0_gnt; drives the pipeline freeze.
- p0_rdata  output  32  registered read data for port 0.
- p0_rvalid  output  1  p0_rdata valid (one-cycle pulse).
- p1_req, p1_we, p1_addr[32], p1_wdata[32]  input  same meaning as port 0.
- p1_gnt, p1_rdata[32], p1_rvalid  output  same meaning as port 0.
- clr_start  input  1  pulse; requests a full memory clear.
- clr_busy  output  1  clear in progress.
- clr_done  output  1  one-cycle pulse when the clear finishes.
- mem_a  output  32  memory byte address.
- mem_wd  output  32  memory write data.
- mem_we  output  1  memory write enable.
- mem_pc  output  32  PC forwarded to memory; 0 for port-1 and clear writes.
- mem_rd  input  32  memory combinational read data.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State=IDLE, wait_cnt=0, clr_idx=0.
  - p0_rvalid=p1_rvalid=0, p0_rdata=p1_rdata=0.
  - clr_busy=0, clr_done=0.
  - Consequently gnt=0, mem_we=0.
- States:
  - IDLE/SERVE (merged as RUN) and CLEAR.
  - RUN -> CLEAR on clr_start=1, with priority over any request that cycle; no grant is issued that cycle.
  - CLEAR -> RUN after writing word DEPTH-1.
- Arbitration in RUN (combinational on current inputs):
  - Grant port 0 if p0_req & ~(p1_req & wait_cnt>=MAX_WAIT).
  - Otherwise grant port 1 if p1_req.
  - At most one gnt high per cycle.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) each cycle p1_req=1 and p1_gnt=0.
  - Clears to 0 on p1_gnt or when p1_req=0.
- Memory drive:
  - Granted port's addr/wdata appear on mem_a/mem_wd; mem_we = granted port's we.
  - With no grant, mem_we=0 and mem_a holds the last driven value.
- Write: committed at the same rising edge as the grant cycle.
- Read: mem_rd is sampled at the grant-cycle edge into px_rdata, and px_rvalid=1 for the following cycle only.
  - Back-to-back reads on one port give back-to-back rvalid.
  - rdata holds its value when rvalid=0.
- Write grants produce no rvalid.
- CLEAR:
  - Each cycle: mem_we=1, mem_a={clr_idx,2'b00}, mem_wd=0, clr_idx++.
  - DEPTH cycles in total; clr_busy=1 throughout.
  - Both gnt=0, so p0_stall follows p0_req.
  - After the last write: clr_done pulses for 1 cycle, clr_busy drops in the same cycle, and clr_idx resets to 0.
- clr_start while clr_busy: ignored.
- Reset mid-CLEAR: the clear is aborted with no clr_done; memory contents are left partially cleared.
- Addresses are passed through unmodified. Bits above [13:2] and bits [1:0] are the memory's concern; no alignment check is made.

Optional Feature:
- Macro DM_ARB_TRACE_EN.
- Defined: on each edge with mem_we=1 from port 0, print "%d@%h: *%h <= %h" with $time, p0_pc-4, mem_a and mem_wd. Port-1 and clear writes print the same format with PC field 00000000.
- Undefined: no $display; logic is otherwise identical.

Test Plan:
- Reset, then p0 write addr=0x10 data=0xDEADBEEF, then p0 read 0x10 -> p0_gnt=1 both cycles; p0_rvalid=1 in the cycle after the read grant with p0_rdata=0xDEADBEEF.
- p0_req and p1_req held high continuously -> p0 granted 4 cycles, p1 force-granted on the 5th cycle, pattern repeats; p0_stall=1 only in the p1-grant cycle.
- Only p1_req, read 0x20 after a p1 write 0x20<=0x12345678 -> p1_rvalid next cycle with 0x12345678; p0_rvalid stays 0.
- Fill 0x0 and 0x2FFC with nonzero data, pulse clr_start with p0_req high -> clr_busy for 3072 cycles, p0_gnt=0 throughout, clr_done single pulse, subsequent reads of 0x0 and 0x2FFC return 0.
- Deassert rst_n asynchronously mid-clear at index 100 -> outputs zero immediately without a clock edge; no clr_done; after release, normal grants resume.
- With DM_ARB_TRACE_EN, p0 write pc=0x3008 addr=0x4 data=0x7 -> log line shows 00003004 and *00000004 <= 00000007.
